hazard_stall_unit: RTL and testbench



---
 rtl/hazard_stall_unit_pkg.sv | 19 +
 rtl/hazard_stall_unit_cmp.sv | 38 +++
 rtl/hazard_stall_unit.sv | 98 +++++++++
 tb/tb_hazard_stall_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the D-stage hazard resolver.
package hazard_stall_unit_pkg;

    localparam int REG_W = 5;

    typedef logic [1:0] tnew_t;
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t   FWD_RF    = 2'd0;
    localparam fwd_sel_t   FWD_M     = 2'd1;
    localparam fwd_sel_t   FWD_E     = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew ages by one per stage and saturates at zero rather than wrapping to 3.
    function automatic tnew_t tnew_decay(input tnew_t t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_cmp.sv
// Single-operand check against the E and M shadow records: stall request and forward select.
module hazard_cmp
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W = hazard_stall_unit_pkg::REG_W
) (
    input  logic [REG_W-1:0] reg_i,
    input  logic [1:0]       tuse_i,
    input  logic [REG_W-1:0] wa_e_i,
    input  tnew_t            tnew_e_i,
    input  logic [REG_W-1:0] wa_m_i,
    input  tnew_t            tnew_m_i,
    output logic             hazard_o,
    output fwd_sel_t         fwd_sel_o
);

    logic reg_live;
    logic hit_e;
    logic hit_m;

    always_comb begin
        reg_live = (reg_i != '0);
        hit_e    = reg_live && (reg_i == wa_e_i);
        hit_m    = reg_live && (reg_i == wa_m_i);

        hazard_o = (hit_e && (tuse_i < tnew_e_i)) ||
                   (hit_m && (tuse_i < tnew_m_i));

        // The E record is the younger writer, so it wins over M.
        fwd_sel_o = FWD_RF;
        if (hit_e && (tnew_e_i == 2'd0)) begin
            fwd_sel_o = FWD_E;
        end else if (hit_m && (tnew_m_i == 2'd0)) begin
            fwd_sel_o = FWD_M;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// D-stage stall/forward resolver with E/M shadow records.
// Optional stall cycle counter port stall_cnt is built only when HAZARD_PERF_EN is defined.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W = hazard_stall_unit_pkg::REG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic [1:0]       Tuse_rs,
    input  logic [1:0]       Tuse_rt,
    input  tnew_t            Tnew_D,
    input  logic [REG_W-1:0] wa_D,
    output logic             stall,
    output fwd_sel_t         fwd_rs_D,
    output fwd_sel_t         fwd_rt_D
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    logic [REG_W-1:0] wa_e_q, wa_e_d;
    logic [REG_W-1:0] wa_m_q, wa_m_d;
    tnew_t            tnew_e_q, tnew_e_d;
    tnew_t            tnew_m_q, tnew_m_d;
    logic             haz_rs, haz_rt;

    hazard_cmp #(.REG_W(REG_W)) u_cmp_rs (
        .reg_i     (rs_D),
        .tuse_i    (Tuse_rs),
        .wa_e_i    (wa_e_q),
        .tnew_e_i  (tnew_e_q),
        .wa_m_i    (wa_m_q),
        .tnew_m_i  (tnew_m_q),
        .hazard_o  (haz_rs),
        .fwd_sel_o (fwd_rs_D)
    );

    hazard_cmp #(.REG_W(REG_W)) u_cmp_rt (
        .reg_i     (rt_D),
        .tuse_i    (Tuse_rt),
        .wa_e_i    (wa_e_q),
        .tnew_e_i  (tnew_e_q),
        .wa_m_i    (wa_m_q),
        .tnew_m_i  (tnew_m_q),
        .hazard_o  (haz_rt),
        .fwd_sel_o (fwd_rt_D)
    );

    assign stall = haz_rs | haz_rt;

    always_comb begin
        wa_e_d   = wa_D;
        tnew_e_d = Tnew_D;
        if (stall) begin
            wa_e_d   = '0;
            tnew_e_d = 2'd0;
        end
        wa_m_d   = wa_e_q;
        tnew_m_d = tnew_decay(tnew_e_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wa_e_q   <= '0;
            tnew_e_q <= 2'd0;
            wa_m_q   <= '0;
            tnew_m_q <= 2'd0;
        end else begin
            wa_e_q   <= wa_e_d;
            tnew_e_q <= tnew_e_d;
            wa_m_q   <= wa_m_d;
            tnew_m_q <= tnew_m_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: vector table with expected-result queue,
// plus a stall counter sequence when HAZARD_PERF_EN is defined.
module tb_hazard_stall_unit;
    import hazard_stall_unit_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D, rt_D, wa_D;
    logic [1:0] Tuse_rs, Tuse_rt, Tnew_D;
    logic       stall;
    logic [1:0] fwd_rs_D, fwd_rt_D;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    hazard_stall_unit #(.REG_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .rs_D     (rs_D),
        .rt_D     (rt_D),
        .Tuse_rs  (Tuse_rs),
        .Tuse_rt  (Tuse_rt),
        .Tnew_D   (Tnew_D),
        .wa_D     (wa_D),
        .stall    (stall),
        .fwd_rs_D (fwd_rs_D),
        .fwd_rt_D (fwd_rt_D)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] urs;
        logic [1:0] urt;
        logic [1:0] tn;
        logic [4:0] wa;
        logic       e_stall;
        logic [1:0] e_frs;
        logic [1:0] e_frt;
    } vec_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] frs;
        logic [1:0] frt;
    } exp_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    exp_t sb_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] urs, input logic [1:0] urt,
                         input logic [1:0] tn, input logic [4:0] wa);
        reset   = r;
        rs_D    = rs;
        rt_D    = rt;
        Tuse_rs = urs;
        Tuse_rt = urt;
        Tnew_D  = tn;
        wa_D    = wa;
    endtask

    initial begin
        exp_t e;
        // rst rs  rt  urs urt tn  wa    stall frs frt
        vecs[0]  = '{1'b0, 5'd29, 5'd0,  2'd1, TUSE_NONE, 2'd2, 5'd8,  1'b0, FWD_RF, FWD_RF}; // lw r8
        vecs[1]  = '{1'b0, 5'd8,  5'd3,  2'd1, 2'd1,      2'd1, 5'd11, 1'b1, FWD_RF, FWD_RF}; // addu uses r8: stall
        vecs[2]  = '{1'b0, 5'd8,  5'd3,  2'd1, 2'd1,      2'd1, 5'd11, 1'b0, FWD_RF, FWD_RF}; // released, load Tnew 1 in M
        vecs[3]  = '{1'b0, 5'd11, 5'd0,  2'd0, 2'd0,      2'd0, 5'd0,  1'b1, FWD_RF, FWD_RF}; // beq on r11: stall
        vecs[4]  = '{1'b0, 5'd11, 5'd0,  2'd0, 2'd0,      2'd0, 5'd0,  1'b0, FWD_M,  FWD_RF}; // forwarded from M
        vecs[5]  = '{1'b0, 5'd29, 5'd0,  2'd1, TUSE_NONE, 2'd2, 5'd10, 1'b0, FWD_RF, FWD_RF}; // lw r10
        vecs[6]  = '{1'b0, 5'd29, 5'd10, 2'd1, 2'd2,      2'd0, 5'd0,  1'b0, FWD_RF, FWD_RF}; // sw data r10: no stall
        vecs[7]  = '{1'b0, 5'd29, 5'd0,  2'd1, TUSE_NONE, 2'd2, 5'd0,  1'b0, FWD_RF, FWD_RF}; // lw to r0
        vecs[8]  = '{1'b0, 5'd0,  5'd0,  2'd0, 2'd0,      2'd1, 5'd12, 1'b0, FWD_RF, FWD_RF}; // r0 reader ignored
        vecs[9]  = '{1'b0, 5'd0,  5'd12, 2'd0, TUSE_NONE, 2'd0, 5'd5,  1'b0, FWD_RF, FWD_RF}; // Tuse none on r12
        vecs[10] = '{1'b0, 5'd12, 5'd5,  2'd1, 2'd1,      2'd0, 5'd5,  1'b0, FWD_M,  FWD_E};  // writer r5 again
        vecs[11] = '{1'b0, 5'd5,  5'd5,  2'd0, TUSE_NONE, 2'd0, 5'd0,  1'b0, FWD_E,  FWD_E};  // E beats M
        vecs[12] = '{1'b0, 5'd5,  5'd7,  2'd0, 2'd0,      2'd2, 5'd7,  1'b0, FWD_M,  FWD_RF}; // lw r7
        vecs[13] = '{1'b0, 5'd7,  5'd0,  2'd0, TUSE_NONE, 2'd0, 5'd0,  1'b1, FWD_RF, FWD_RF}; // branch on load: stall 1
        vecs[14] = '{1'b0, 5'd7,  5'd0,  2'd0, TUSE_NONE, 2'd0, 5'd0,  1'b1, FWD_RF, FWD_RF}; // stall 2 from M
        vecs[15] = '{1'b0, 5'd7,  5'd0,  2'd0, TUSE_NONE, 2'd0, 5'd0,  1'b0, FWD_RF, FWD_RF}; // load gone to W
        vecs[16] = '{1'b0, 5'd29, 5'd0,  2'd1, TUSE_NONE, 2'd2, 5'd9,  1'b0, FWD_RF, FWD_RF}; // lw r9
        vecs[17] = '{1'b1, 5'd0,  5'd9,  TUSE_NONE, 2'd0, 2'd0, 5'd0,  1'b1, FWD_RF, FWD_RF}; // rt stall, reset asserted
        vecs[18] = '{1'b0, 5'd0,  5'd9,  TUSE_NONE, 2'd0, 2'd0, 5'd0,  1'b0, FWD_RF, FWD_RF}; // records cleared

        drive(1'b1, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 2'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        check("reset_cnt", stall_cnt, 32'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt,
                  vecs[i].tn, vecs[i].wa);
            sb_q.push_back('{vecs[i].e_stall, vecs[i].e_frs, vecs[i].e_frt});
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check($sformatf("sb_empty[%0d]", i), 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("stall[%0d]", i), {31'd0, stall}, {31'd0, e.stall});
                check($sformatf("fwd_rs[%0d]", i), {30'd0, fwd_rs_D}, {30'd0, e.frs});
                check($sformatf("fwd_rt[%0d]", i), {30'd0, fwd_rt_D}, {30'd0, e.frt});
            end
            @(posedge clk);
            #1;
        end

`ifdef HAZARD_PERF_EN
        check("cnt_after_reset", stall_cnt, 32'd0);
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 5'd29, 5'd0, 2'd1, TUSE_NONE, 2'd2, 5'd8);
            @(posedge clk); #1;
            drive(1'b0, 5'd8, 5'd0, 2'd1, TUSE_NONE, 2'd1, 5'd0);
            @(negedge clk);
            check($sformatf("pair_stall[%0d]", p), {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("pair_release[%0d]", p), {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
        end
        check("cnt_three", stall_cnt, 32'd3);
        drive(1'b0, 5'd29, 5'd0, 2'd1, TUSE_NONE, 2'd2, 5'd8);
        @(posedge clk); #1;
        drive(1'b1, 5'd8, 5'd0, 2'd1, TUSE_NONE, 2'd1, 5'd0);
        @(negedge clk);
        check("mid_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        check("cnt_cleared", stall_cnt, 32'd0);
        check("stall_cleared", {31'd0, stall}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
